// File: rtl/keypoint_packer.sv
`default_nettype none
// ============================================================================
//  Module      : keypoint_packer
//  Description : Walks a raster-ordered sample stream, keeps flagged keypoints
//                that lie outside the image border, queues them as packed
//                {X,Y,orientation,score} words and closes every completed
//                frame with a trailer word carrying the keypoint count.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypoint_packer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int BORDER = 16,
    parameter int DEPTH  = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_end,
    input  logic        i_flag,
    input  logic [7:0]  i_score,
    input  logic [9:0]  i_orientation,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [37:0] o_data,
    output logic        o_trailer,
    output logic [15:0] o_drop_count,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [9:0]  c_x_max   = 10'(WIDTH - 1);
    localparam logic [9:0]  c_y_max   = 10'(HEIGHT - 1);
    localparam logic [9:0]  c_x_lo    = 10'(BORDER);
    localparam logic [9:0]  c_x_hi    = 10'(WIDTH - BORDER);
    localparam logic [9:0]  c_y_lo    = 10'(BORDER);
    localparam logic [9:0]  c_y_hi    = 10'(HEIGHT - BORDER);
    localparam logic [AW:0] c_depth   = (AW + 1)'(DEPTH);
    localparam logic [9:0]  c_kp_max  = 10'h3FF;
    localparam logic [15:0] c_drp_max = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [9:0]      kp_q, kp_d;
    logic [15:0]     drop_q, drop_d;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic [37:0]     mem_q [DEPTH];

    logic            w_sample;
    logic            w_restart;
    logic [9:0]      w_x;
    logic [9:0]      w_y;
    logic            w_last;
    logic            w_accept;
    logic            w_fifo_rd;
    logic            w_fifo_wr;
    logic            w_drop;
    logic            w_trl_xfer;
    logic [37:0]     w_word;

    // Sample qualification and FIFO handshake decode for the current cycle
    always_comb begin
        // A start pulse outside S_FLUSH always makes this cycle sample (0,0)
        w_restart  = i_start && (state_q != S_FLUSH);
        w_sample   = (state_q == S_FRAME) || w_restart;
        w_x        = w_restart ? 10'd0 : x_q;
        w_y        = w_restart ? 10'd0 : y_q;
        w_last     = (w_x == c_x_max) && (w_y == c_y_max);
        w_accept   = w_sample && i_flag &&
                     (w_x >= c_x_lo) && (w_x < c_x_hi) &&
                     (w_y >= c_y_lo) && (w_y < c_y_hi);
        w_fifo_rd  = (cnt_q != '0) && i_ready;
        // A read in the same cycle frees a slot even when the FIFO is full
        w_fifo_wr  = w_accept && ((cnt_q != c_depth) || w_fifo_rd);
        w_drop     = w_accept && !w_fifo_wr;
        w_trl_xfer = (state_q == S_FLUSH) && (cnt_q == '0) && i_ready;
        w_word     = {w_x, w_y, i_orientation, i_score};
    end

    // Next-state logic for the frame FSM, raster position and counters
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        kp_d    = w_restart ? 10'd0 : kp_q;
        drop_d  = drop_q;

        case (state_q)
            S_IDLE, S_FRAME: begin
                if (w_sample) begin
                    if (i_end || w_last) begin
                        state_d = S_FLUSH;
                        x_d     = 10'd0;
                        y_d     = 10'd0;
                    end else begin
                        state_d = S_FRAME;
                        if (w_x == c_x_max) begin
                            x_d = 10'd0;
                            y_d = w_y + 10'd1;
                        end else begin
                            x_d = w_x + 10'd1;
                            y_d = w_y;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (w_trl_xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_fifo_wr && (kp_d != c_kp_max)) begin
            kp_d = kp_d + 10'd1;
        end
        if (w_drop && (drop_q != c_drp_max)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // State, position, counter and FIFO pointer registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            kp_q     <= 10'd0;
            drop_q   <= 16'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            kp_q    <= kp_d;
            drop_q  <= drop_d;
            if (w_fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + (w_fifo_wr ? 1'b1 : 1'b0) - (w_fifo_rd ? 1'b1 : 1'b0);
        end
    end

    // Keypoint storage; contents are don't-care while the count says empty
    always_ff @(posedge i_clk) begin
        if (w_fifo_wr && !i_rst) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

    // Output word selection, driven purely from registered state
    always_comb begin
        o_valid      = 1'b0;
        o_trailer    = 1'b0;
        o_data       = 38'd0;
        o_drop_count = drop_q;
        o_busy       = (state_q != S_IDLE);
        if (cnt_q != '0) begin
            o_valid = 1'b1;
            o_data  = mem_q[rd_ptr_q];
        end else if (state_q == S_FLUSH) begin
            o_valid   = 1'b1;
            o_trailer = 1'b1;
            o_data    = {28'd0, kp_q};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypoint_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypoint_packer
//  Description : Self-checking bench for keypoint_packer; expected words are
//                queued as samples are driven and matched on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypoint_packer;

    localparam int W     = 128;
    localparam int H     = 64;
    localparam int B     = 16;
    localparam int DEPTH = 64;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_end;
    logic        i_flag;
    logic [7:0]  i_score;
    logic [9:0]  i_orientation;
    logic        o_valid;
    logic        i_ready;
    logic [37:0] o_data;
    logic        o_trailer;
    logic [15:0] o_drop_count;
    logic        o_busy;

    keypoint_packer #(
        .WIDTH  (W),
        .HEIGHT (H),
        .BORDER (B),
        .DEPTH  (DEPTH)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_end         (i_end),
        .i_flag        (i_flag),
        .i_score       (i_score),
        .i_orientation (i_orientation),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_trailer     (o_trailer),
        .o_drop_count  (o_drop_count),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        trl;
        logic [37:0] data;
    } sb_t;

    sb_t         sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          data_cnt = 0;
    int          drops    = 0;
    int          kp       = 0;
    bit          stall_q  = 0;
    logic [37:0] hold_data = '0;

    int fx[$];
    int fy[$];
    int fsc[$];
    int fo[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_flag(input int x, input int y);
        for (int i = 0; i < fx.size(); i++) begin
            if (fx[i] == x && fy[i] == y) return i;
        end
        return -1;
    endfunction

    function automatic bit inside_area(input int x, input int y);
        return (x >= B) && (x < W - B) && (y >= B) && (y < H - B);
    endfunction

    function automatic logic [37:0] pack(input int x, input int y, input int o, input int sc);
        return {10'(x), 10'(y), 10'(o), 8'(sc)};
    endfunction

    function automatic bit pick_ready(input int rmode);
        if (rmode == 2) return bit'($urandom_range(1, 0));
        return (rmode == 1);
    endfunction

    // One clock: check outputs at the falling edge, then update the model
    task automatic tick(input bit acc, input logic [37:0] word);
        sb_t e;
        @(negedge clk);
        if (stall_q) begin
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_data", 64'(o_data), 64'(hold_data));
        end
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'(o_data), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk(e.trl ? "trailer_data" : "kp_data", 64'(o_data), 64'(e.data));
                chk("trailer_flag", 64'(o_trailer), 64'(e.trl));
                if (!e.trl) data_cnt--;
            end
        end
        stall_q   = o_valid && !i_ready;
        hold_data = o_data;
        if (acc) begin
            if (data_cnt < DEPTH) begin
                sb.push_back('{trl: 1'b0, data: word});
                data_cnt++;
                if (kp < 1023) kp++;
            end else begin
                if (drops < 16'hFFFF) drops++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; end_s < 0 lets it run to the last raster sample,
    // abort_s >= 0 reissues i_start at that sample index of the first frame
    task automatic run_frame(input int end_s, input int abort_s, input int rmode);
        int  s   = 0;
        int  tot = 0;
        bit  ab  = 0;
        bit  st;
        bit  last;
        int  x, y, k;
        bit  acc;
        while (tot < 4 * W * H) begin
            st = (tot == 0) || (!ab && abort_s >= 0 && s == abort_s);
            if (st && tot != 0) begin
                s  = 0;
                ab = 1;
            end
            if (st) kp = 0;
            x    = s % W;
            y    = s / W;
            last = (s == W * H - 1) || (s == end_s);
            k    = find_flag(x, y);
            i_start       = st;
            i_end         = (s == end_s);
            i_flag        = (k >= 0);
            i_score       = (k >= 0) ? 8'(fsc[k]) : 8'($urandom);
            i_orientation = (k >= 0) ? 10'(fo[k]) : 10'($urandom);
            i_ready       = pick_ready(rmode);
            acc = (k >= 0) && inside_area(x, y);
            tick(acc, (k >= 0) ? pack(x, y, fo[k], fsc[k]) : 38'd0);
            tot++;
            s++;
            if (last) break;
        end
        i_start = 0;
        i_end   = 0;
        i_flag  = 0;
        sb.push_back('{trl: 1'b1, data: 38'(kp)});
    endtask

    task automatic drain(input int rmode);
        int n = 0;
        while ((sb.size() > 0 || o_busy) && n < 4000) begin
            i_ready = pick_ready(rmode);
            tick(1'b0, 38'd0);
            n++;
        end
        chk("drain_timeout", 64'(n >= 4000), 64'd0);
        chk("busy_after", 64'(o_busy), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        i_ready = 1'b1;
    endtask

    task automatic do_reset();
        i_rst   = 1;
        i_ready = 0;
        i_start = 0;
        i_end   = 0;
        i_flag  = 0;
        @(posedge clk);
        #1;
        i_rst = 0;
        sb.delete();
        data_cnt = 0;
        drops    = 0;
        kp       = 0;
        stall_q  = 0;
        @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_drop", 64'(o_drop_count), 64'd0);
        chk("rst_trailer", 64'(o_trailer), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        @(posedge clk);
        #1;
        i_ready = 1;
    endtask

    task automatic clear_flags();
        fx.delete(); fy.delete(); fsc.delete(); fo.delete();
    endtask

    task automatic add_flag(input int x, input int y, input int sc, input int o);
        fx.push_back(x); fy.push_back(y); fsc.push_back(sc); fo.push_back(o);
    endtask

    task automatic test1();
        clear_flags();
        add_flag(100, 40, 37, 5);
        run_frame(-1, -1, 1);
        drain(1);
    endtask

    initial begin
        i_rst = 1; i_start = 0; i_end = 0; i_flag = 0;
        i_score = 0; i_orientation = 0; i_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single keypoint, full frame ending on the last raster sample
        test1();

        // Border rejects on every side plus the innermost accepted corners
        clear_flags();
        add_flag(15, 30, 1, 1);
        add_flag(112, 30, 2, 2);
        add_flag(100, 15, 3, 3);
        add_flag(100, 48, 4, 4);
        add_flag(16, 16, 5, 6);
        add_flag(111, 47, 7, 8);
        run_frame(-1, -1, 1);
        drain(1);

        // Back-pressure for the whole frame: FIFO fills and the rest drop
        clear_flags();
        for (int i = 0; i < 70; i++) add_flag(16 + i, 20, i + 3, 2 * i + 1);
        run_frame(21 * W, -1, 0);
        chk("drop_count", 64'(o_drop_count), 64'd6);
        chk("drop_model", 64'(o_drop_count), 64'(drops));
        chk("held_valid", 64'(o_valid), 64'd1);
        drain(1);

        // Random back-pressure
        clear_flags();
        for (int i = 0; i < 30; i++) add_flag(20 + 2 * i, 30, 100 + i, 500 + i);
        run_frame(31 * W, -1, 2);
        drain(2);

        // Frame aborted at sample 1000 and restarted
        clear_flags();
        add_flag(30, 20, 11, 12);
        add_flag(40, 25, 13, 14);
        run_frame(26 * W, 1000, 1);
        drain(1);

        // Reset with ten words held, then a clean frame
        clear_flags();
        for (int i = 0; i < 10; i++) add_flag(20 + i, 20, i, i);
        run_frame(21 * W, -1, 0);
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        do_reset();
        test1();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypoint_packer.md
KEYPOINT_PACKER -- requirements
Module: keypoint_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 480, image height in lines.
REQ-003 SHALL have parameter BORDER, default 16, margin in pixels; keypoints inside it are discarded.
REQ-004 SHALL have parameter DEPTH, default 64, keypoint FIFO depth (power of 2, ≥4).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port i_clk, input, 1 bit, the clock; all logic samples on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit, the synchronous active-high reset.
REQ-008 SHALL have port i_start, input, 1 bit, frame-start pulse; the same cycle carries sample 0.
REQ-009 SHALL have port i_end, input, 1 bit, frame-end pulse from the upstream detector.
REQ-010 SHALL have port i_flag, input, 1 bit, post-NMS keypoint flag for the current sample.
REQ-011 SHALL have port i_score, input, 8 bits, FAST score for the current sample.
REQ-012 SHALL have port i_orientation, input, 10 bits, orientation for the current sample.
REQ-013 SHALL have port o_valid, output, 1 bit, output word valid.
REQ-014 SHALL have port i_ready, input, 1 bit, downstream accepts the word.
REQ-015 SHALL have port o_data, output, 38 bits: {X[37:28], Y[27:18], orientation[17:8], score[7:0]}; for a trailer word it is {28'd0, kp_count[9:0]}.
REQ-016 SHALL have port o_trailer, output, 1 bit, marks the end-of-frame trailer word.
REQ-017 SHALL have port o_drop_count, output, 16 bits, keypoints dropped because the FIFO was full.
REQ-018 SHALL have port o_busy, output, 1 bit, high while in S_FRAME or S_FLUSH.

Function
REQ-019 SHALL implement the states S_IDLE, S_FRAME and S_FLUSH.
REQ-020 S_IDLE: when i_start=1, SHALL go to S_FRAME, treat the current cycle as sample (X=0,Y=0), and clear kp_count.
REQ-021 S_FRAME: SHALL treat one sample per cycle in raster order; X increments and wraps at WIDTH-1 to 0, and Y then increments.
REQ-022 S_FRAME: SHALL leave for S_FLUSH on i_end=1 or after sample (WIDTH-1,HEIGHT-1), whichever comes first; that last sample is still processed.
REQ-023 Sample qualification: SHALL accept a sample when i_flag=1 AND BORDER≤X<WIDTH-BORDER AND BORDER≤Y<HEIGHT-BORDER; all other samples are ignored.
REQ-024 An accepted sample SHALL be written to the FIFO as the REQ-015 word if FIFO occupancy < DEPTH; otherwise it is dropped and o_drop_count increments, saturating at 16'hFFFF.
REQ-025 kp_count SHALL count written keypoints only (excluding drops), saturating at 1023.
REQ-026 S_FLUSH: SHALL wait until the FIFO is empty, then present the trailer word (o_trailer=1, kp_count) and return to S_IDLE on its handshake.
REQ-027 Handshake: a word transfers when o_valid&&i_ready; o_valid and o_data SHALL stay stable until transfer; o_valid SHALL not depend combinationally on i_ready.
REQ-028 FIFO SHALL allow write and read in the same cycle, including when full (the read frees a slot, so the write succeeds) and when empty (write only).
REQ-029 FIFO data SHALL appear at the output no earlier than the cycle after it is written (1-cycle minimum latency from accepted flag to o_valid).
REQ-030 i_start in S_FRAME SHALL abort the frame: restart at (0,0), clear kp_count, emit no trailer, and keep FIFO contents.
REQ-031 i_start in S_FLUSH SHALL be ignored; upstream must not start a frame before o_busy falls.
REQ-032 i_flag in S_IDLE or S_FLUSH SHALL be ignored.
REQ-033 Widths: X and Y SHALL be 10 bits; WIDTH and HEIGHT are ≤1024.

Reset
REQ-034 While i_rst=1, at the next edge: state=S_IDLE, X=Y=0, FIFO empty, kp_count=0, o_valid=0, o_trailer=0, o_data=0, o_drop_count=0, o_busy=0.
REQ-035 Reset mid-frame SHALL discard all FIFO contents and any pending trailer; i_rst takes priority over all inputs.

Verification
REQ-036 Test 1: WIDTH=640, HEIGHT=480, i_ready=1; i_flag only at (100,50) with score 37 and orientation 5 -> one word {100,50,5,37}, then a trailer with count 1, then o_busy=0.
REQ-037 Test 2: i_flag at (15,50), (624,50), (100,15) and (100,464) -> no keypoint words; trailer count 0.
REQ-038 Test 3: i_ready=0 for the whole frame, 70 qualifying flags, DEPTH=64 -> 64 words held, o_drop_count=6; on releasing i_ready, 64 words in order, then trailer count 64.
REQ-039 Test 4: i_ready toggled randomly -> no word lost or duplicated; o_data stable while o_valid&&!i_ready (scoreboard check).
REQ-040 Test 5: i_start reasserted mid-frame at sample 1000 -> coordinates restart at (0,0); only one trailer, carrying the count for the new frame.
REQ-041 Test 6: i_rst asserted with FIFO holding 10 words -> next cycle o_valid=0, o_busy=0, o_drop_count=0; a following frame behaves as in Test 1.
